osc_bank: RTL

Parametrised multi-voice oscillator bank: VOICES independent period counters, each with its own divider, enable and phase-sync input. Each voice counts 1..divider and wraps, emits a one-cycle wrap pulse and, optionally, a square-wave output. Divider changes take effect only at a wrap boundary, so pitch changes are glitch-free. Sits between the note/key decoder, which supplies dividers, and the waveform/mixer stage.

---
 rtl/osc_bank.sv | 87 ++++++++
 1 files changed

// File: rtl/osc_bank.sv
// Multi-voice oscillator bank: per-voice period counter with glitch-free divider reload.
// Optional square outputs built only when OSC_BANK_SQUARE_EN is defined.
module osc_bank #(
  parameter int unsigned VOICES = 4,
  parameter int unsigned WIDTH  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [VOICES-1:0]         en,
  input  logic [VOICES-1:0]         sync,
  input  logic [VOICES*WIDTH-1:0]   divider,
  output logic [VOICES*WIDTH-1:0]   count,
  output logic [VOICES-1:0]         wrap,
  output logic [VOICES-1:0]         square
);

  logic [WIDTH-1:0]  cnt     [VOICES];
  logic [WIDTH-1:0]  act_div [VOICES];
  logic [VOICES-1:0] wrap_q;
  logic [VOICES-1:0] roll;

  // Rollover uses >= so a count stranded above a shrunken divider wraps at once.
  always_comb begin
    roll = '0;
    for (int unsigned v = 0; v < VOICES; v++) begin
      roll[v] = !sync[v] && en[v] && (act_div[v] != '0) && (cnt[v] >= act_div[v]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned v = 0; v < VOICES; v++) begin
        cnt[v]     <= WIDTH'(1);
        act_div[v] <= WIDTH'(1);
      end
      wrap_q <= '0;
    end else begin
      for (int unsigned v = 0; v < VOICES; v++) begin
        wrap_q[v] <= 1'b0;
        if (sync[v]) begin
          cnt[v]     <= WIDTH'(1);
          act_div[v] <= divider[v*WIDTH +: WIDTH];
        end else if (!en[v]) begin
          act_div[v] <= divider[v*WIDTH +: WIDTH];
        end else if (act_div[v] == '0) begin
          cnt[v]     <= WIDTH'(1);
          act_div[v] <= divider[v*WIDTH +: WIDTH];
        end else if (roll[v]) begin
          cnt[v]     <= WIDTH'(1);
          wrap_q[v]  <= 1'b1;
          act_div[v] <= divider[v*WIDTH +: WIDTH];
        end else begin
          cnt[v] <= cnt[v] + WIDTH'(1);
        end
      end
    end
  end

`ifdef OSC_BANK_SQUARE_EN
  logic [VOICES-1:0] sq_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sq_q <= '0;
    end else begin
      for (int unsigned v = 0; v < VOICES; v++) begin
        if (sync[v])      sq_q[v] <= 1'b0;
        else if (roll[v]) sq_q[v] <= ~sq_q[v];
      end
    end
  end

  assign square = sq_q;
`else
  assign square = '0;
`endif

  always_comb begin
    count = '0;
    for (int unsigned v = 0; v < VOICES; v++) begin
      count[v*WIDTH +: WIDTH] = cnt[v];
    end
  end

  assign wrap = wrap_q;

endmodule
